// File: rtl/store_unit_pkg.sv
// Shared definitions for the store path: RISC-V store width encodings
// (funct3[1:0]) common to the load decoder and the store encoder.
package store_unit_pkg;

    // Store/load access width, funct3[1:0]
    localparam logic [1:0] ENCDEC_BYTE = 2'b00;
    localparam logic [1:0] ENCDEC_HALF = 2'b01;
    localparam logic [1:0] ENCDEC_WORD = 2'b10;

    // Byte-lane shift amount for a byte offset within a word
    function automatic logic [4:0] lane_shift(input logic [1:0] ofs);
        return {ofs, 3'b000};
    endfunction

endpackage : store_unit_pkg

// File: rtl/store_unit_word_encode.sv
// Combinational store encoder: places the store field on its byte lanes,
// builds the byte strobes and flags illegal or misaligned stores.
module word_encode
    import store_unit_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] data_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic        unaligned_o
);

    logic [4:0] shamt;

    assign shamt = lane_shift(addr_lo_i);

    // Lane-shift and strobe generation; illegal stores drive all-zero lanes
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        wdata_o     = '0;
        wstrb_o     = '0;
        unaligned_o = 1'b1;
        if (!funct3_i[2]) begin
            unique case (funct3_i[1:0])
                ENCDEC_BYTE: begin
                    wdata_o     = {24'h0, data_i[7:0]} << shamt;
                    wstrb_o     = 4'b0001 << addr_lo_i;
                    unaligned_o = 1'b0;
                end
                ENCDEC_HALF: begin
                    if (addr_lo_i != 2'b11) begin
                        wdata_o     = {16'h0, data_i[15:0]} << shamt;
                        wstrb_o     = 4'b0011 << addr_lo_i;
                        unaligned_o = 1'b0;
                    end
                end
                ENCDEC_WORD: begin
                    if (addr_lo_i == 2'b00) begin
                        wdata_o     = data_i;
                        wstrb_o     = 4'hF;
                        unaligned_o = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : word_encode

// File: rtl/store_unit.sv
// Store unit: accepts one store request, issues a single word-aligned
// write on the data-memory port, and reports done / fault / bus_err pulses.
module store_unit
    import store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TCNT_W  = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        done,
    output logic        fault,
    output logic        bus_err,
    output logic [31:0] fault_addr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        FAULT = 2'd2
    } state_e;

    localparam bit              TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [TCNT_W-1:0] TCNT_LAST =
        (TIMEOUT == 0) ? '0 : TCNT_W'(TIMEOUT - 1);

    state_e             state_q;
    logic [TCNT_W-1:0]  tcnt_q;
    logic [31:0]        req_addr_q;
    logic               mem_valid_q;
    logic [31:0]        mem_addr_q;
    logic [31:0]        mem_wdata_q;
    logic [3:0]         mem_wstrb_q;
    logic               done_q;
    logic               fault_q;
    logic               bus_err_q;
    logic [31:0]        fault_addr_q;

    logic [31:0]        enc_wdata_d;
    logic [3:0]         enc_wstrb_d;
    logic               enc_bad_d;

    word_encode u_word_encode (
        .funct3_i    (req_funct3),
        .addr_lo_i   (req_addr[1:0]),
        .data_i      (req_data),
        .wdata_o     (enc_wdata_d),
        .wstrb_o     (enc_wstrb_d),
        .unaligned_o (enc_bad_d)
    );

    // Ready is gated by reset so nothing can be accepted while reset is held
    assign req_ready  = (state_q == IDLE) & rst_n;
    assign mem_valid  = mem_valid_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign done       = done_q;
    assign fault      = fault_q;
    assign bus_err    = bus_err_q;
    assign fault_addr = fault_addr_q;

    // Control FSM with registered outputs, synchronous active-low reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q      <= IDLE;
            tcnt_q       <= '0;
            req_addr_q   <= '0;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
            bus_err_q    <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            // Status outputs are single-cycle pulses unless set below
            done_q    <= 1'b0;
            fault_q   <= 1'b0;
            bus_err_q <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        if (enc_bad_d) begin
                            fault_addr_q <= req_addr;
                            fault_q      <= 1'b1;
                            state_q      <= FAULT;
                        end else begin
                            req_addr_q  <= req_addr;
                            mem_addr_q  <= {req_addr[31:2], 2'b00};
                            mem_wdata_q <= enc_wdata_d;
                            mem_wstrb_q <= enc_wstrb_d;
                            mem_valid_q <= 1'b1;
                            state_q     <= ISSUE;
                        end
                    end
                end

                ISSUE: begin
                    // Handshake wins over a timeout on the same cycle
                    if (mem_ready) begin
                        mem_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                        tcnt_q      <= '0;
                        state_q     <= IDLE;
                    end else if (TIMEOUT_EN && (tcnt_q == TCNT_LAST)) begin
                        mem_valid_q  <= 1'b0;
                        bus_err_q    <= 1'b1;
                        fault_addr_q <= req_addr_q;
                        tcnt_q       <= '0;
                        state_q      <= IDLE;
                    end else begin
                        tcnt_q <= tcnt_q + TCNT_W'(1);
                    end
                end

                FAULT: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule : store_unit

// File: tb/tb_store_unit.sv
// Directed bench for store_unit with a scoreboard of expected outcomes.
module tb_store_unit;

    typedef enum int {K_DONE = 0, K_FAULT = 1, K_BERR = 2} kind_e;

    typedef struct {
        kind_e       kind;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        done;
    logic        fault;
    logic        bus_err;
    logic [31:0] fault_addr;

    exp_t sb[$];
    int   n_cmp;
    int   n_err;
    int   cyc;
    int   mv_run;
    int   last_mv_run;
    int   done_cycs[$];

    store_unit #(.TIMEOUT(16), .TCNT_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .done       (done),
        .fault      (fault),
        .bus_err    (bus_err),
        .fault_addr (fault_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference encoding built lane by lane from the byte offset
    function automatic exp_t model(logic [2:0] f3, logic [31:0] a, logic [31:0] d, bit berr);
        exp_t e;
        int   ofs;
        bit   legal;
        ofs     = int'(a[1:0]);
        e.addr  = a;
        e.wdata = '0;
        e.wstrb = '0;
        legal   = 1'b0;
        case (f3)
            3'b000: begin legal = 1'b1; e.wstrb[ofs] = 1'b1; end
            3'b001: begin
                legal = (ofs < 3);
                if (legal) begin e.wstrb[ofs] = 1'b1; e.wstrb[ofs+1] = 1'b1; end
            end
            3'b010: begin legal = (ofs == 0); if (legal) e.wstrb = 4'hF; end
            default: legal = 1'b0;
        endcase
        for (int i = 0; i < 4; i++)
            if (e.wstrb[i]) e.wdata[8*i +: 8] = d[8*(i-ofs) +: 8];
        e.kind = !legal ? K_FAULT : (berr ? K_BERR : K_DONE);
        return e;
    endfunction

    // One clock: sample outputs 1ns after the edge and run the scoreboard
    task automatic tick();
        exp_t  e;
        kind_e k;
        @(posedge clk);
        #1;
        cyc++;
        if (mem_valid) begin
            mv_run++;
            if (sb.size() == 0) check("mem_valid_unexpected", 32'd1, 32'd0);
            else begin
                check("mem_addr", mem_addr, {sb[0].addr[31:2], 2'b00});
                check("mem_wdata", mem_wdata, sb[0].wdata);
                check("mem_wstrb", 32'(mem_wstrb), 32'(sb[0].wstrb));
            end
        end
        if (done || fault || bus_err) begin
            check("pulse_exclusive", 32'(done) + 32'(fault) + 32'(bus_err), 32'd1);
            if (done) done_cycs.push_back(cyc);
            if (sb.size() == 0) check("pulse_unexpected", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                k = done ? K_DONE : (fault ? K_FAULT : K_BERR);
                check("pulse_kind", 32'(k), 32'(e.kind));
                if (k != K_DONE) check("fault_addr", fault_addr, e.addr);
                last_mv_run = mv_run;
                mv_run      = 0;
            end
        end
    endtask

    // Present a request and hold it until accepted (bounded)
    task automatic send(logic [2:0] f3, logic [31:0] a, logic [31:0] d, bit berr);
        bit acc;
        int n;
        acc        = 1'b0;
        n          = 0;
        req_valid  = 1'b1;
        req_funct3 = f3;
        req_addr   = a;
        req_data   = d;
        while (!acc && n < 50) begin
            if (req_ready) begin
                sb.push_back(model(f3, a, d, berr));
                acc = 1'b1;
            end
            tick();
            n++;
        end
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
        req_valid = 1'b0;
    endtask

    // Wait for the next done/fault/bus_err pulse (bounded)
    task automatic wait_pulse(string tag, int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(done || fault || bus_err) && n < budget);
        if (!(done || fault || bus_err)) check(tag, 32'd0, 32'd1);
    endtask

    initial begin
        int c0;
        n_cmp       = 0;
        n_err       = 0;
        cyc         = 0;
        mv_run      = 0;
        last_mv_run = 0;
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_funct3  = '0;
        req_addr    = '0;
        req_data    = '0;
        mem_ready   = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_pulses", {29'd0, done, fault, bus_err}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        check("rst_fault_addr", fault_addr, 32'd0);
        rst_n = 1'b1;
        #1;
        check("idle_req_ready", 32'(req_ready), 32'd1);

        // SB to lane 3, zero-wait memory: done two cycles after accept
        mem_ready = 1'b1;
        send(3'b000, 32'h0000_1003, 32'h0000_00AB, 1'b0);
        check("sb_mem_valid", 32'(mem_valid), 32'd1);
        check("sb_mem_addr", mem_addr, 32'h0000_1000);
        check("sb_mem_wdata", mem_wdata, 32'hAB00_0000);
        check("sb_mem_wstrb", 32'(mem_wstrb), 32'b1000);
        check("sb_req_ready_busy", 32'(req_ready), 32'd0);
        tick();
        check("sb_done", 32'(done), 32'd1);
        check("sb_mem_valid_drop", 32'(mem_valid), 32'd0);
        tick();
        check("sb_done_single", 32'(done), 32'd0);

        // SH at offset 1, then misaligned SH at offset 3
        send(3'b001, 32'h0000_2001, 32'h0000_1234, 1'b0);
        check("sh_mem_wdata", mem_wdata, 32'h0012_3400);
        check("sh_mem_wstrb", 32'(mem_wstrb), 32'b0110);
        wait_pulse("sh_done_timeout", 10);
        check("sh_done", 32'(done), 32'd1);
        send(3'b001, 32'h0000_2003, 32'h0000_5678, 1'b0);
        check("sh_fault", 32'(fault), 32'd1);
        check("sh_fault_addr", fault_addr, 32'h0000_2003);
        check("sh_fault_no_mem", 32'(last_mv_run), 32'd0);
        tick();
        check("sh_fault_single", 32'(fault), 32'd0);

        // SW with five wait cycles: six stable mem_valid cycles, one done
        mem_ready = 1'b0;
        send(3'b010, 32'h0000_3000, 32'hDEAD_BEEF, 1'b0);
        repeat (5) tick();
        mem_ready = 1'b1;
        wait_pulse("sw_done_timeout", 10);
        check("sw_done", 32'(done), 32'd1);
        check("sw_valid_cycles", 32'(last_mv_run), 32'd6);
        send(3'b010, 32'h0000_3002, 32'hDEAD_BEEF, 1'b0);
        check("sw_misaligned_fault", 32'(fault), 32'd1);
        tick();

        // Timeout: memory never ready
        mem_ready = 1'b0;
        send(3'b010, 32'h0000_4000, 32'h1111_2222, 1'b1);
        wait_pulse("berr_timeout", 40);
        check("berr_pulse", 32'(bus_err), 32'd1);
        check("berr_valid_cycles", 32'(last_mv_run), 32'd16);
        check("berr_fault_addr", fault_addr, 32'h0000_4000);
        check("berr_req_ready", 32'(req_ready), 32'd1);
        mem_ready = 1'b1;
        c0 = cyc;
        send(3'b000, 32'h0000_4001, 32'h0000_0077, 1'b0);
        check("berr_accept_same_cycle", 32'(cyc - c0), 32'd1);
        wait_pulse("post_berr_done_timeout", 10);
        check("post_berr_done", 32'(done), 32'd1);

        // Illegal funct3 encodings
        send(3'b100, 32'h0000_5000, 32'h0000_0001, 1'b0);
        check("f3_100_fault", 32'(fault), 32'd1);
        tick();
        send(3'b011, 32'h0000_5004, 32'h0000_0002, 1'b0);
        check("f3_011_fault", 32'(fault), 32'd1);
        tick();

        // Three back-to-back SB: done pulses two cycles apart
        done_cycs.delete();
        send(3'b000, 32'h0000_6000, 32'h0000_0011, 1'b0);
        send(3'b000, 32'h0000_6001, 32'h0000_0022, 1'b0);
        send(3'b000, 32'h0000_6002, 32'h0000_0033, 1'b0);
        wait_pulse("b2b_done_timeout", 10);
        check("b2b_done_count", 32'(done_cycs.size()), 32'd3);
        if (done_cycs.size() == 3) begin
            check("b2b_gap_1", 32'(done_cycs[1] - done_cycs[0]), 32'd2);
            check("b2b_gap_2", 32'(done_cycs[2] - done_cycs[1]), 32'd2);
        end
        check("b2b_sb_empty", 32'(sb.size()), 32'd0);

        // Reset during ISSUE abandons the write
        mem_ready = 1'b0;
        send(3'b010, 32'h0000_7000, 32'hCAFE_F00D, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        check("rst_mid_req_ready", 32'(req_ready), 32'd0);
        tick();
        sb.delete();
        mv_run = 0;
        check("rst_mid_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_mid_no_done", {30'd0, done, bus_err}, 32'd0);
        mem_ready = 1'b1;
        tick();
        check("rst_mid_no_done_held", 32'(done), 32'd0);
        rst_n = 1'b1;
        #1;
        send(3'b010, 32'h0000_8000, 32'h0BAD_CAFE, 1'b0);
        wait_pulse("post_rst_done_timeout", 10);
        check("post_rst_done", 32'(done), 32'd1);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule : tb_store_unit
